// File: rtl/hazard_pkg.sv
// Shared defaults and hazard-cause encoding for the pipeline hazard scoreboard.
package hazard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOAD    = 2'd1,
    CAUSE_BR_EX   = 2'd2,
    CAUSE_BR_LOAD = 2'd3
  } hazard_cause_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: ID/EX/MEM register info in, stall controls and statistics out.
interface hazard_scoreboard_if import hazard_pkg::*; #(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [REG_W-1:0]      ID_rs;
  logic [REG_W-1:0]      ID_rt;
  logic                  ID_useRs;
  logic                  ID_useRt;
  logic                  ID_uncertainJump;
  logic [REG_W-1:0]      EX_rw;
  logic                  EX_regWrite;
  logic                  EX_memToReg;
  logic [REG_W-1:0]      MEM_rw;
  logic                  MEM_memToReg;
  logic                  MEM_ready;
  logic                  stall;
  logic                  memStall;
  logic [2**REG_W-1:0]   pending;
  logic [CNT_W-1:0]      stallCycles;
  logic [CNT_W-1:0]      memStallCycles;
  logic                  memTimeout;

  modport master (
    output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_uncertainJump,
    output EX_rw, EX_regWrite, EX_memToReg,
    output MEM_rw, MEM_memToReg, MEM_ready,
    input  stall, memStall, pending, stallCycles, memStallCycles, memTimeout
  );

  modport slave (
    input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_uncertainJump,
    input  EX_rw, EX_regWrite, EX_memToReg,
    input  MEM_rw, MEM_memToReg, MEM_ready,
    output stall, memStall, pending, stallCycles, memStallCycles, memTimeout
  );

endinterface

// File: rtl/hazard_scoreboard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter import hazard_pkg::*; #(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch hazard detection with a pending-load scoreboard, memory-stall
// freeze, saturating statistics and a sticky memory-timeout flag.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_W        = REG_W_DEF,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TIMEOUT      = 255
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int NREG   = 2**REG_W;
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic BR_EN = (BRANCH_IN_ID != 0);

  logic [NREG-1:0]   pending_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout_q;
  logic              ex_match;
  logic              haz_load;
  logic              haz_br_ex;
  logic              haz_br_load;
  logic              mem_stall;
  logic              stall_w;
  logic              pend_set;
  logic              pend_clr;
  hazard_cause_e     cause;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  assign ex_match = (bus.EX_rw != '0) &&
                    ((bus.ID_useRs && (bus.ID_rs == bus.EX_rw)) ||
                     (bus.ID_useRt && (bus.ID_rt == bus.EX_rw)));

  assign haz_load    = bus.EX_memToReg && ex_match;
  assign haz_br_ex   = BR_EN && bus.ID_uncertainJump && bus.EX_regWrite && ex_match;
  assign haz_br_load = BR_EN && bus.ID_uncertainJump &&
                       ((pending_q[bus.ID_rs] && bus.ID_useRs) ||
                        (pending_q[bus.ID_rt] && bus.ID_useRt));

  always_comb begin
    cause = CAUSE_NONE;
    if (haz_br_load) cause = CAUSE_BR_LOAD;
    if (haz_br_ex)   cause = CAUSE_BR_EX;
    if (haz_load)    cause = CAUSE_LOAD;
  end

  // A frozen pipe must not also receive a bubble, so memStall masks stall.
  assign mem_stall = bus.MEM_memToReg && !bus.MEM_ready;
  assign stall_w   = (cause != CAUSE_NONE) && !mem_stall;

  assign pend_set = bus.EX_memToReg && (bus.EX_rw != '0) && !mem_stall;
  assign pend_clr = bus.MEM_memToReg && bus.MEM_ready;

  // Set is applied after clear so a back-to-back load to the same register stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      if (pend_clr) pending_q[bus.MEM_rw] <= 1'b0;
      if (pend_set) pending_q[bus.EX_rw]  <= 1'b1;
    end
  end

  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (mem_stall) begin
      wait_q <= wait_inc;
      if (wait_inc == WAIT_MAX) timeout_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_w),
    .count (bus.stallCycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mem_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_stall),
    .count (bus.memStallCycles)
  );

  assign bus.stall      = stall_w;
  assign bus.memStall   = mem_stall;
  assign bus.pending    = pending_q;
  assign bus.memTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives two scoreboard variants (default build and a no-branch/4-bit/TIMEOUT=4 build)
// from one stimulus stream and compares both against a behavioural model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rw = '0, mem_rw = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_unc = 1'b0;
  logic       ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
  logic       mem_mem_to_reg = 1'b0, mem_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  // Model state: index 0 is dut_a, index 1 is dut_b.
  bit     pend [32];
  longint s_cnt [2];
  longint m_cnt [2];
  int     w_cnt [2];
  bit     tmo   [2];
  bit     br_en [2] = '{1'b1, 1'b0};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd15};
  int     tlim  [2] = '{255, 4};

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(5), .CNT_W(32)) bus_a ();
  hazard_scoreboard_if #(.REG_W(5), .CNT_W(4))  bus_b ();

  assign bus_a.ID_rs = id_rs;                  assign bus_b.ID_rs = id_rs;
  assign bus_a.ID_rt = id_rt;                  assign bus_b.ID_rt = id_rt;
  assign bus_a.ID_useRs = id_use_rs;           assign bus_b.ID_useRs = id_use_rs;
  assign bus_a.ID_useRt = id_use_rt;           assign bus_b.ID_useRt = id_use_rt;
  assign bus_a.ID_uncertainJump = id_unc;      assign bus_b.ID_uncertainJump = id_unc;
  assign bus_a.EX_rw = ex_rw;                  assign bus_b.EX_rw = ex_rw;
  assign bus_a.EX_regWrite = ex_reg_write;     assign bus_b.EX_regWrite = ex_reg_write;
  assign bus_a.EX_memToReg = ex_mem_to_reg;    assign bus_b.EX_memToReg = ex_mem_to_reg;
  assign bus_a.MEM_rw = mem_rw;                assign bus_b.MEM_rw = mem_rw;
  assign bus_a.MEM_memToReg = mem_mem_to_reg;  assign bus_b.MEM_memToReg = mem_mem_to_reg;
  assign bus_a.MEM_ready = mem_ready;          assign bus_b.MEM_ready = mem_ready;

  hazard_scoreboard #(.REG_W(5), .BRANCH_IN_ID(1), .CNT_W(32), .TIMEOUT(255)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  hazard_scoreboard #(.REG_W(5), .BRANCH_IN_ID(0), .CNT_W(4), .TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit exp_mstall();
    return mem_mem_to_reg && !mem_ready;
  endfunction

  function automatic bit exp_stall(int d);
    bit m, ld, bex, bld;
    m   = (ex_rw != 0) && ((id_use_rs && id_rs == ex_rw) || (id_use_rt && id_rt == ex_rw));
    ld  = ex_mem_to_reg && m;
    bex = br_en[d] && id_unc && ex_reg_write && m;
    bld = br_en[d] && id_unc && ((pend[id_rs] && id_use_rs) || (pend[id_rt] && id_use_rt));
    return (ld || bex || bld) && !exp_mstall();
  endfunction

  function automatic logic [63:0] exp_pend();
    logic [63:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 6))
      0: return 5'd0;
      1: return 5'd4;
      2: return 5'd5;
      3: return 5'd7;
      4: return 5'd8;
      5: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_cnt[d] = 0; m_cnt[d] = 0; w_cnt[d] = 0; tmo[d] = 1'b0;
    end
  endtask

  // Applies one rising edge to the model; stall is decided on the pre-edge scoreboard.
  task automatic modelEdge();
    bit st [2];
    bit ms;
    ms = exp_mstall();
    for (int d = 0; d < 2; d++) st[d] = exp_stall(d);
    for (int d = 0; d < 2; d++) begin
      if (st[d] && s_cnt[d] < cmax[d]) s_cnt[d]++;
      if (ms && m_cnt[d] < cmax[d]) m_cnt[d]++;
      if (ms) begin
        if (w_cnt[d] < tlim[d]) w_cnt[d]++;
        if (w_cnt[d] >= tlim[d]) tmo[d] = 1'b1;
      end else begin
        w_cnt[d] = 0;
      end
    end
    if (mem_mem_to_reg && mem_ready) pend[mem_rw] = 1'b0;
    if (ex_mem_to_reg && ex_rw != 0 && !ms) pend[ex_rw] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "/a.stall"},    64'(bus_a.stall),          64'(exp_stall(0)));
    chk({tag, "/b.stall"},    64'(bus_b.stall),          64'(exp_stall(1)));
    chk({tag, "/a.memStall"}, 64'(bus_a.memStall),       64'(exp_mstall()));
    chk({tag, "/b.memStall"}, 64'(bus_b.memStall),       64'(exp_mstall()));
    chk({tag, "/a.pending"},  64'(bus_a.pending),        exp_pend());
    chk({tag, "/b.pending"},  64'(bus_b.pending),        exp_pend());
    chk({tag, "/a.stallCnt"}, 64'(bus_a.stallCycles),    64'(s_cnt[0]));
    chk({tag, "/b.stallCnt"}, 64'(bus_b.stallCycles),    64'(s_cnt[1]));
    chk({tag, "/a.memCnt"},   64'(bus_a.memStallCycles), 64'(m_cnt[0]));
    chk({tag, "/b.memCnt"},   64'(bus_b.memStallCycles), 64'(m_cnt[1]));
    chk({tag, "/a.timeout"},  64'(bus_a.memTimeout),     64'(tmo[0]));
    chk({tag, "/b.timeout"},  64'(bus_b.memTimeout),     64'(tmo[1]));
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic unc,
                               input logic [4:0] exrw, input logic exw, input logic exl,
                               input logic [4:0] memrw, input logic meml, input logic rdy);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_unc = unc;
    ex_rw = exrw; ex_reg_write = exw; ex_mem_to_reg = exl;
    mem_rw = memrw; mem_mem_to_reg = meml; mem_ready = rdy;
  endtask

  task automatic sampleMid(input string tag);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
  endtask

  // Called at posedge+1: pulls reset low mid-cycle, checks the async clear, releases after an edge.
  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "/a.pending0"}, 64'(bus_a.pending),        64'd0);
    chk({tag, "/b.pending0"}, 64'(bus_b.pending),        64'd0);
    chk({tag, "/a.stall0"},   64'(bus_a.stallCycles),    64'd0);
    chk({tag, "/b.mem0"},     64'(bus_b.memStallCycles), 64'd0);
    chk({tag, "/b.tmo0"},     64'(bus_b.memTimeout),     64'd0);
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("por/a.pending", 64'(bus_a.pending),     64'd0);
    chk("por/b.timeout", 64'(bus_b.memTimeout),  64'd0);
    rst_n = 1'b1;
    sampleMid("idle");
    clockEdge();

    // Load-use: lw $8 in EX, add reads $8 in ID.
    applyStimulus(5'd8, 5'd3, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 1);
    sampleMid("lw8");
    chk("lw8/stall", 64'(bus_a.stall), 64'd1);
    clockEdge();
    chk("lw8/pend8", 64'(bus_a.pending[8]), 64'd1);
    applyStimulus(5'd8, 5'd3, 1, 1, 0, 5'd0, 0, 0, 5'd8, 1, 1);
    sampleMid("lw8mem");
    chk("lw8mem/stall", 64'(bus_a.stall), 64'd0);
    clockEdge();

    // beq reads $9 while addi writes $9 in EX.
    applyStimulus(5'd1, 5'd9, 1, 1, 1, 5'd9, 1, 0, 5'd0, 0, 1);
    sampleMid("beq9");
    chk("beq9/a.stall", 64'(bus_a.stall), 64'd1);
    chk("beq9/b.stall", 64'(bus_b.stall), 64'd0);
    clockEdge();

    // Load to $5 waits 3 cycles in MEM while EX holds lw $6 with a dependent ID.
    doReset("r26");
    applyStimulus(5'd1, 5'd2, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, 1);
    sampleMid("lw5");
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd6, 5'd2, 1, 0, 0, 5'd6, 1, 1, 5'd5, 1, 0);
      sampleMid("mwait");
      chk("mwait/a.memStall", 64'(bus_a.memStall), 64'd1);
      chk("mwait/a.stall",    64'(bus_a.stall),    64'd0);
      clockEdge();
    end
    chk("mwait/a.memCnt", 64'(bus_a.memStallCycles), 64'd3);
    chk("mwait/b.memCnt", 64'(bus_b.memStallCycles), 64'd3);
    chk("mwait/pend6",    64'(bus_a.pending[6]),     64'd0);
    applyStimulus(5'd6, 5'd2, 1, 0, 0, 5'd6, 1, 1, 5'd5, 1, 1);
    sampleMid("mready");
    clockEdge();
    chk("mready/pend5", 64'(bus_a.pending[5]), 64'd0);
    chk("mready/pend6", 64'(bus_a.pending[6]), 64'd1);

    // Back-to-back lw $7: set and clear on the same edge.
    applyStimulus(5'd1, 5'd2, 0, 0, 0, 5'd7, 1, 1, 5'd6, 1, 1);
    sampleMid("lw7a");
    clockEdge();
    applyStimulus(5'd1, 5'd2, 0, 0, 0, 5'd7, 1, 1, 5'd7, 1, 1);
    sampleMid("lw7b");
    clockEdge();
    chk("lw7/pend7", 64'(bus_a.pending[7]), 64'd1);

    // Memory timeout on dut_b (TIMEOUT=4), sticky after ready, async reset mid-stall.
    doReset("r28");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 0);
      sampleMid("tmo");
      clockEdge();
      chk("tmo/b.flag", 64'(bus_b.memTimeout), (i == 4) ? 64'd1 : 64'd0);
    end
    chk("tmo/a.flag", 64'(bus_a.memTimeout), 64'd0);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 1);
    sampleMid("tmordy");
    clockEdge();
    chk("tmordy/b.flag", 64'(bus_b.memTimeout), 64'd1);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 0);
    sampleMid("tmo2");
    clockEdge();
    doReset("r28rst");
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1);

    // 20 load-use stalls: dut_b's 4-bit counter must stick at 15.
    doReset("r29");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'd4, 5'd0, 1, 0, 0, 5'd4, 1, 1, 5'd0, 0, 1);
      sampleMid("sat");
      clockEdge();
    end
    chk("sat/a.stallCnt", 64'(bus_a.stallCycles), 64'd20);
    chk("sat/b.stallCnt", 64'(bus_b.stallCycles), 64'd15);
    applyStimulus(5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 1, 5'd0, 0, 1);
    sampleMid("r0");
    chk("r0/a.stall", 64'(bus_a.stall), 64'd0);
    clockEdge();
    chk("r0/pend0", 64'(bus_a.pending[0]), 64'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
      sampleMid("rnd");
      clockEdge();
    end
    sampleMid("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
